// File: rtl/omp_ram_pkg.sv
// Shared encodings for the dual-port RAM: same-port write modes and the
// clear-sequencer state type.
package omp_ram_pkg;

    localparam int WM_WRITE_FIRST = 0;
    localparam int WM_READ_FIRST  = 1;
    localparam int WM_NO_CHANGE   = 2;

    typedef enum logic [0:0] {
        CLR_CLEAR = 1'b0,
        CLR_READY = 1'b1
    } clr_state_e;

    // Bits needed to index MEM_SIZE words (at least one).
    function automatic int idx_width(input int mem_size);
        return (mem_size > 1) ? $clog2(mem_size) : 1;
    endfunction

endpackage

// File: rtl/omp_ram_dp_if.sv
// Two-port RAM access bundle. A port access is accepted on a rising edge when its
// ce is high and busy is low; anything presented while busy is dropped, no retry.
interface omp_ram_dp_if #(
    parameter int DWIDTH = 32,
    parameter int AWIDTH = 7
);

    logic [AWIDTH-1:0]   addr0;
    logic [AWIDTH-1:0]   addr1;
    logic                ce0;
    logic                ce1;
    logic [DWIDTH/8-1:0] we0;
    logic [DWIDTH/8-1:0] we1;
    logic [DWIDTH-1:0]   d0;
    logic [DWIDTH-1:0]   d1;
    logic [DWIDTH-1:0]   q0;
    logic [DWIDTH-1:0]   q1;
    logic                busy;
    logic                collision;

    modport master (
        output addr0, addr1, ce0, ce1, we0, we1, d0, d1,
        input  q0, q1, busy, collision
    );

    modport slave (
        input  addr0, addr1, ce0, ce1, we0, we1, d0, d1,
        output q0, q1, busy, collision
    );

endinterface

// File: rtl/omp_ram_clr.sv
// Post-reset clear sequencer: sweeps every word address once, writing zero,
// then parks in READY until the next reset.
module omp_ram_clr
    import omp_ram_pkg::*;
#(
    parameter int AWIDTH         = 7,
    parameter int MEM_SIZE       = 128,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              reset,
    output logic              busy_o,
    output logic [AWIDTH-1:0] clr_addr_o,
    output logic              clr_we_o,
    output clr_state_e        state_o
);

    localparam clr_state_e        RESET_STATE = (CLEAR_ON_RESET != 0) ? CLR_CLEAR : CLR_READY;
    localparam logic [AWIDTH-1:0] LAST_ADDR   = AWIDTH'(MEM_SIZE - 1);

    clr_state_e        state_q;
    logic [AWIDTH-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_STATE;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                CLR_CLEAR: begin
                    if (cnt_q == LAST_ADDR) begin
                        state_q <= CLR_READY;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= CLR_READY;
            endcase
        end
    end

    assign busy_o     = (state_q == CLR_CLEAR);
    assign clr_we_o   = (state_q == CLR_CLEAR);
    assign clr_addr_o = cnt_q;
    assign state_o    = state_q;

endmodule

// File: rtl/omp_ram_dp.sv
// True dual-port byte-writable RAM with selectable same-port read-during-write
// behaviour, optional output register, collision flag and zero-fill after reset.
module omp_ram_dp
    import omp_ram_pkg::*;
#(
    parameter int DWIDTH         = 32,
    parameter int AWIDTH         = 7,
    parameter int MEM_SIZE       = 128,
    parameter int WRITE_MODE     = 0,
    parameter int OUT_REG        = 0,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic         clk,
    input  logic         reset,
    omp_ram_dp_if.slave  bus,
    output clr_state_e   dbg_state_o
);

    localparam int NB = DWIDTH / 8;
    localparam int IW = idx_width(MEM_SIZE);

    logic              busy;
    logic              clr_we;
    logic [AWIDTH-1:0] clr_addr;

    omp_ram_clr #(
        .AWIDTH         (AWIDTH),
        .MEM_SIZE       (MEM_SIZE),
        .CLEAR_ON_RESET (CLEAR_ON_RESET)
    ) u_clr (
        .clk        (clk),
        .reset      (reset),
        .busy_o     (busy),
        .clr_addr_o (clr_addr),
        .clr_we_o   (clr_we),
        .state_o    (dbg_state_o)
    );

    (* ram_style = "block" *) logic [DWIDTH-1:0] mem [MEM_SIZE];

    logic              acc_ok;
    logic              in0, in1, rd0, rd1, wr0, wr1, same_addr;
    logic [DWIDTH-1:0] old0, old1, new0, new1;
    logic [DWIDTH-1:0] q0_s1_q, q1_s1_q, q0_s1_d, q1_s1_d;
    logic              coll_q, coll_d;

    // Reset cycles count as busy so no port write slips in while the sequencer restarts.
    assign acc_ok    = !busy && !reset;
    assign in0       = 32'(bus.addr0) < MEM_SIZE;
    assign in1       = 32'(bus.addr1) < MEM_SIZE;
    assign rd0       = acc_ok && bus.ce0;
    assign rd1       = acc_ok && bus.ce1;
    assign wr0       = rd0 && in0 && (|bus.we0);
    assign wr1       = rd1 && in1 && (|bus.we1);
    assign same_addr = (bus.addr0 == bus.addr1);
    assign coll_d    = rd0 && rd1 && in0 && same_addr && (wr0 || wr1);

    assign old0 = in0 ? mem[bus.addr0[IW-1:0]] : '0;
    assign old1 = in1 ? mem[bus.addr1[IW-1:0]] : '0;

    // Word as stored after this edge; on a shared address both ports see the final merge.
    always_comb begin
        new0 = old0;
        new1 = old1;
        for (int b = 0; b < NB; b++) begin
            if (wr1 && bus.we1[b]) begin
                new1[8*b +: 8] = bus.d1[8*b +: 8];
                if (same_addr) new0[8*b +: 8] = bus.d1[8*b +: 8];
            end
            if (wr0 && bus.we0[b]) begin
                new0[8*b +: 8] = bus.d0[8*b +: 8];
                if (same_addr) new1[8*b +: 8] = bus.d0[8*b +: 8];
            end
        end
    end

    always_comb begin
        q0_s1_d = q0_s1_q;
        if (busy) begin
            q0_s1_d = '0;
        end else if (bus.ce0) begin
            if (!in0) begin
                q0_s1_d = '0;
            end else if (|bus.we0) begin
                if (WRITE_MODE == WM_WRITE_FIRST)     q0_s1_d = new0;
                else if (WRITE_MODE == WM_READ_FIRST) q0_s1_d = old0;
            end else begin
                q0_s1_d = old0;
            end
        end
    end

    always_comb begin
        q1_s1_d = q1_s1_q;
        if (busy) begin
            q1_s1_d = '0;
        end else if (bus.ce1) begin
            if (!in1) begin
                q1_s1_d = '0;
            end else if (|bus.we1) begin
                if (WRITE_MODE == WM_WRITE_FIRST)     q1_s1_d = new1;
                else if (WRITE_MODE == WM_READ_FIRST) q1_s1_d = old1;
            end else begin
                q1_s1_d = old1;
            end
        end
    end

    // Port 0 byte writes come last so they win where both ports hit the same byte.
    always_ff @(posedge clk) begin
        if (clr_we) mem[clr_addr[IW-1:0]] <= '0;
        for (int b = 0; b < NB; b++) begin
            if (wr1 && bus.we1[b]) mem[bus.addr1[IW-1:0]][8*b +: 8] <= bus.d1[8*b +: 8];
            if (wr0 && bus.we0[b]) mem[bus.addr0[IW-1:0]][8*b +: 8] <= bus.d0[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q0_s1_q <= '0;
            q1_s1_q <= '0;
            coll_q  <= 1'b0;
        end else begin
            q0_s1_q <= q0_s1_d;
            q1_s1_q <= q1_s1_d;
            coll_q  <= coll_d;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DWIDTH-1:0] q0_s2_q, q1_s2_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    q0_s2_q <= '0;
                    q1_s2_q <= '0;
                end else begin
                    q0_s2_q <= q0_s1_q;
                    q1_s2_q <= q1_s1_q;
                end
            end

            assign bus.q0 = q0_s2_q;
            assign bus.q1 = q1_s2_q;
        end else begin : g_no_out_reg
            assign bus.q0 = q0_s1_q;
            assign bus.q1 = q1_s1_q;
        end
    endgenerate

    assign bus.busy      = busy;
    assign bus.collision = coll_q;

endmodule
